// File: rtl/perf_counter_sampler.sv
// Periodic IO-bus sweeper for the performance counter block: select each index, read it back,
// and queue {index, value} samples in a small FIFO drained over a valid/ready port.
module perf_counter_sampler #(
    parameter int          NUM_COUNTERS    = 4,
    parameter logic [31:0] BASE_ADDRESS    = 32'h0,
    parameter int          SAMPLE_INTERVAL = 1024,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          IDX_WIDTH       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic [31:0]          io_address,
    output logic                 io_write_en,
    output logic [31:0]          io_write_data,
    output logic                 io_read_en,
    input  logic [31:0]          io_read_data,
    output logic                 sample_valid,
    output logic [IDX_WIDTH-1:0] sample_index,
    output logic [31:0]          sample_value,
    input  logic                 sample_ready,
    output logic                 overflow,
    input  logic                 overflow_clear,
    output logic                 sweep_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [TW-1:0]        TIMER_RELOAD = TW'(SAMPLE_INTERVAL - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX     = IDX_WIDTH'(NUM_COUNTERS - 1);
    localparam logic [PW-1:0]        DEPTH_P      = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_READ   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [IDX_WIDTH-1:0] r_index;
    logic                 r_io_write_en;
    logic                 r_io_read_en;
    logic [31:0]          r_io_address;
    logic [31:0]          r_io_write_data;
    logic                 r_sweep_done;
    logic                 r_overflow;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [IDX_WIDTH-1:0] r_mem_idx [FIFO_DEPTH];
    logic [31:0]          r_mem_val [FIFO_DEPTH];

    logic [IDX_WIDTH-1:0] w_next_index;
    logic [PW-1:0]        w_count;
    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_push_ok;
    logic                 w_drop;

    assign w_next_index = r_index + IDX_WIDTH'(1);
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_valid      = (w_count != '0);
    assign w_full       = (w_count == DEPTH_P);
    assign w_pop        = w_valid & sample_ready;
    assign w_push       = (r_state == S_READ);
    // A full FIFO still accepts the sample when the head leaves in the same cycle.
    assign w_push_ok    = w_push & (~w_full | w_pop);
    assign w_drop       = w_push & ~w_push_ok;

    // Bus strobes are registered one state ahead so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_timer         <= TIMER_RELOAD;
            r_index         <= '0;
            r_io_write_en   <= 1'b0;
            r_io_read_en    <= 1'b0;
            r_io_address    <= '0;
            r_io_write_data <= '0;
            r_sweep_done    <= 1'b0;
        end else begin
            r_io_write_en   <= 1'b0;
            r_io_read_en    <= 1'b0;
            r_io_address    <= '0;
            r_io_write_data <= '0;
            r_sweep_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (r_timer == '0) begin
                            r_state       <= S_SELECT;
                            r_index       <= '0;
                            r_io_write_en <= 1'b1;
                            r_io_address  <= BASE_ADDRESS;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                end
                S_SELECT: begin
                    r_state      <= S_READ;
                    r_io_read_en <= 1'b1;
                    r_io_address <= BASE_ADDRESS;
                end
                S_READ: begin
                    if (r_index == LAST_IDX) begin
                        r_state      <= S_DONE;
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_state         <= S_SELECT;
                        r_index         <= w_next_index;
                        r_io_write_en   <= 1'b1;
                        r_io_address    <= BASE_ADDRESS;
                        r_io_write_data <= {{(32-IDX_WIDTH){1'b0}}, w_next_index};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_timer <= TIMER_RELOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_drop)
                r_overflow <= 1'b1;
            else if (overflow_clear)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_idx[r_wr_ptr[AW-1:0]] <= r_index;
            r_mem_val[r_wr_ptr[AW-1:0]] <= io_read_data;
        end
    end

    assign io_address    = r_io_address;
    assign io_write_en   = r_io_write_en;
    assign io_write_data = r_io_write_data;
    assign io_read_en    = r_io_read_en;
    assign sweep_done    = r_sweep_done;
    assign overflow      = r_overflow;
    assign sample_valid  = w_valid;
    // Storage is not reset, so the head fields are masked while the FIFO is empty.
    assign sample_index  = w_valid ? r_mem_idx[r_rd_ptr[AW-1:0]] : '0;
    assign sample_value  = w_valid ? r_mem_val[r_rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: behavioural counter responder, a negedge scoreboard of
// expected samples, and one task per scenario.
module tb_perf_counter_sampler;
    localparam int          NC   = 4;
    localparam int          SI   = 8;
    localparam int          FD   = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] io_address;
    logic        io_write_en;
    logic [31:0] io_write_data;
    logic        io_read_en;
    logic [31:0] io_read_data;
    logic        sample_valid;
    logic [1:0]  sample_index;
    logic [31:0] sample_value;
    logic        sample_ready;
    logic        overflow;
    logic        overflow_clear;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] base_val [NC];
    logic        live = 1'b0;
    logic [31:0] live_cnt = 32'd0;
    logic [31:0] r_sel = 32'd0;

    logic [33:0] exp_q [$];
    logic        exp_ovf = 1'b0;
    int          rd_num = 0;
    int          pops_total = 0;
    int          done_total = 0;

    perf_counter_sampler #(
        .NUM_COUNTERS   (NC),
        .BASE_ADDRESS   (BASE),
        .SAMPLE_INTERVAL(SI),
        .FIFO_DEPTH     (FD),
        .IDX_WIDTH      (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .io_address    (io_address),
        .io_write_en   (io_write_en),
        .io_write_data (io_write_data),
        .io_read_en    (io_read_en),
        .io_read_data  (io_read_data),
        .sample_valid  (sample_valid),
        .sample_index  (sample_index),
        .sample_value  (sample_value),
        .sample_ready  (sample_ready),
        .overflow      (overflow),
        .overflow_clear(overflow_clear),
        .sweep_done    (sweep_done)
    );

    always #5 clk = ~clk;

    // Counter block responder: index register written by the sampler, value read combinationally.
    assign io_read_data = (r_sel < NC) ? base_val[r_sel[1:0]] + (live ? live_cnt : 32'd0) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (io_write_en) r_sel <= io_write_data;
        if (live) live_cnt <= live_cnt + 32'd1;
    end

    // Scoreboard: expected samples are pushed on each bus read and compared when the consumer pops.
    always @(negedge clk) begin
        logic        pop;
        logic        push_ok;
        logic [33:0] head;
        if (!reset_n) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            rd_num  = 0;
        end else begin
            pop     = sample_valid && sample_ready;
            push_ok = (exp_q.size() < FD) || pop;
            checks++;
            if (sample_valid !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL sb_valid: got %b expected %b", sample_valid, exp_q.size() > 0);
            end
            checks++;
            if (overflow !== exp_ovf) begin
                errors++;
                $display("FAIL sb_overflow: got %b expected %b", overflow, exp_ovf);
            end
            checks++;
            if ((io_write_en & io_read_en) !== 1'b0) begin
                errors++;
                $display("FAIL sb_strobes: write_en %b read_en %b both set", io_write_en, io_read_en);
            end
            if (pop) begin
                checks++;
                pops_total++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got idx %0d val %h expected no sample", sample_index, sample_value);
                end else begin
                    head = exp_q.pop_front();
                    if ({sample_index, sample_value} !== head) begin
                        errors++;
                        $display("FAIL sb_sample: got idx %0d val %h expected idx %0d val %h",
                                 sample_index, sample_value, head[33:32], head[31:0]);
                    end
                end
            end
            checks++;
            if (io_write_en) begin
                if (io_address !== BASE || io_write_data !== 32'(rd_num)) begin
                    errors++;
                    $display("FAIL sb_select: got addr %h data %h expected addr %h data %h",
                             io_address, io_write_data, BASE, 32'(rd_num));
                end
            end else if (io_read_en) begin
                if (io_address !== BASE || io_write_data !== 32'd0) begin
                    errors++;
                    $display("FAIL sb_read: got addr %h data %h expected addr %h data 0",
                             io_address, io_write_data, BASE);
                end
                if (push_ok)
                    exp_q.push_back({rd_num[1:0], base_val[rd_num] + (live ? live_cnt : 32'd0)});
                rd_num = (rd_num == NC - 1) ? 0 : rd_num + 1;
            end else begin
                if (io_address !== 32'd0 || io_write_data !== 32'd0) begin
                    errors++;
                    $display("FAIL sb_bus_idle: got addr %h data %h expected 0 0", io_address, io_write_data);
                end
            end
            if (io_read_en && !push_ok)
                exp_ovf = 1'b1;
            else if (overflow_clear)
                exp_ovf = 1'b0;
            if (sweep_done) done_total++;
        end
    end

    task automatic wait_select(output int n, input int max);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (io_write_en === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_done(output int n, input int max);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; sample_ready = 1'b0; overflow_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({io_write_en, io_read_en, sample_valid, overflow, sweep_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {io_write_en, io_read_en, sample_valid, overflow, sweep_done});
        end
        checks++;
        if (io_address !== 32'd0 || io_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h expected 0 0", io_address, io_write_data);
        end
        checks++;
        if (sample_index !== 2'd0 || sample_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_sample: got idx %0d val %h expected 0 0", sample_index, sample_value);
        end
    endtask

    task automatic test_basic_sweep();
        int n;
        int d0;
        logic ew, er;
        @(posedge clk); #1;
        reset_n = 1'b1; enable = 1'b1; sample_ready = 1'b1;
        wait_select(n, 40);
        checks++;
        if (n != SI + 1) begin
            errors++;
            $display("FAIL first_select: got cycle %0d expected %0d", n, SI + 1);
        end
        d0 = done_total;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            ew = (j < 8) && (j % 2 == 0);
            er = (j % 2 == 1);
            checks++;
            if ({io_write_en, io_read_en, sweep_done} !== {ew, er, j == 8}) begin
                errors++;
                $display("FAIL basic_seq[%0d]: got wr/rd/done %b expected %b", j,
                         {io_write_en, io_read_en, sweep_done}, {ew, er, j == 8});
            end
            if (j == 2) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_index !== 2'd0 || sample_value !== 32'h10) begin
                    errors++;
                    $display("FAIL basic_latency: got v %b idx %0d val %h expected 1 0 10",
                             sample_valid, sample_index, sample_value);
                end
            end
        end
        wait_select(n, 40);
        checks++;
        if (n != SI + 1) begin
            errors++;
            $display("FAIL basic_period: got cycle %0d after done expected %0d", n, SI + 1);
        end
        checks++;
        if (done_total - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d expected 1", done_total - d0);
        end
        wait_done(n, 40);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL basic_second_done: got timeout expected sweep_done");
        end
    endtask

    task automatic test_overflow();
        int n;
        int p0;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        wait_select(n, 40);
        wait_done(n, 60);
        checks++;
        if (n < 0 || overflow !== 1'b1 || sample_valid !== 1'b1 || sample_index !== 2'd0 || sample_value !== 32'h10) begin
            errors++;
            $display("FAIL ovf_set: got done %0d ovf %b v %b idx %0d val %h expected ovf 1 v 1 idx 0 val 10",
                     n, overflow, sample_valid, sample_index, sample_value);
        end
        enable = 1'b0;
        @(posedge clk); #1 overflow_clear = 1'b1;
        @(posedge clk); #1 overflow_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: got ovf %b v %b expected 0 1", overflow, sample_valid);
        end
        p0 = pops_total;
        @(posedge clk); #1 sample_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (sample_index !== 2'd0 || sample_value !== 32'h10) begin
            errors++;
            $display("FAIL ovf_drain0: got idx %0d val %h expected 0 10", sample_index, sample_value);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_index !== 2'd1 || sample_value !== 32'h20) begin
            errors++;
            $display("FAIL ovf_drain1: got v %b idx %0d val %h expected 1 1 20", sample_valid, sample_index, sample_value);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || pops_total - p0 != 2) begin
            errors++;
            $display("FAIL ovf_drained: got v %b pops %0d expected 0 2", sample_valid, pops_total - p0);
        end
    endtask

    task automatic test_full_pop();
        int n;
        int p0;
        sample_ready = 1'b0;
        enable = 1'b1;
        p0 = pops_total;
        wait_select(n, 40);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 5) sample_ready = 1'b1;
            @(negedge clk);
            if (j == 4 || j == 5) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_index !== 2'd0 || sample_value !== 32'h10) begin
                    errors++;
                    $display("FAIL full_head[%0d]: got v %b idx %0d val %h expected 1 0 10",
                             j, sample_valid, sample_index, sample_value);
                end
            end
            if (j == 6) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_index !== 2'd1 || sample_value !== 32'h20) begin
                    errors++;
                    $display("FAIL full_after_pop: got v %b idx %0d val %h expected 1 1 20",
                             sample_valid, sample_index, sample_value);
                end
            end
            if (j == 8) begin
                checks++;
                if (sweep_done !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_done: got done %b ovf %b expected 1 0", sweep_done, overflow);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || pops_total - p0 != 4) begin
            errors++;
            $display("FAIL full_drained: got v %b pops %0d expected 0 4", sample_valid, pops_total - p0);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        logic ew, er, saw;
        sample_ready = 1'b1;
        enable = 1'b1;
        wait_select(n, 40);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 2) enable = 1'b0;
            @(negedge clk);
            ew = (j < 8) && (j % 2 == 0);
            er = (j % 2 == 1);
            checks++;
            if ({io_write_en, io_read_en, sweep_done} !== {ew, er, j == 8}) begin
                errors++;
                $display("FAIL endrop_seq[%0d]: got wr/rd/done %b expected %b", j,
                         {io_write_en, io_read_en, sweep_done}, {ew, er, j == 8});
            end
        end
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (io_write_en !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL endrop_idle: got select while disabled expected none");
        end
        @(posedge clk); #1 enable = 1'b1;
        wait_select(n, 40);
        checks++;
        if (n != SI + 1) begin
            errors++;
            $display("FAIL endrop_resume: got cycle %0d expected %0d", n, SI + 1);
        end
        wait_done(n, 40);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        sample_ready = 1'b0;
        wait_select(n, 40);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (io_read_en !== 1'b1 || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got rd %b v %b expected 1 1", io_read_en, sample_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({io_write_en, io_read_en, sample_valid, overflow, sweep_done} !== 5'b0 ||
            io_address !== 32'd0 || io_write_data !== 32'd0 || sample_index !== 2'd0 || sample_value !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: got flags %b addr %h data %h idx %0d val %h expected all 0",
                     {io_write_en, io_read_en, sample_valid, overflow, sweep_done},
                     io_address, io_write_data, sample_index, sample_value);
        end
        @(posedge clk); #1;
        sample_ready = 1'b1;
        reset_n = 1'b1;
        wait_select(n, 40);
        checks++;
        if (n != SI + 1) begin
            errors++;
            $display("FAIL rst_first_select: got cycle %0d expected %0d", n, SI + 1);
        end
        wait_done(n, 40);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_live_counters();
        int n;
        int p0;
        int d0;
        live = 1'b1;
        sample_ready = 1'b1;
        p0 = pops_total;
        d0 = done_total;
        wait_done(n, 40);
        wait_done(n, 40);
        repeat (3) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || pops_total - p0 != 8 || done_total - d0 != 2) begin
            errors++;
            $display("FAIL live_counts: got v %b pops %0d dones %0d expected 0 8 2",
                     sample_valid, pops_total - p0, done_total - d0);
        end
        live = 1'b0;
    endtask

    initial begin
        base_val[0] = 32'h10;
        base_val[1] = 32'h20;
        base_val[2] = 32'h30;
        base_val[3] = 32'h40;
        test_reset();
        test_basic_sweep();
        test_overflow();
        test_full_pop();
        test_enable_drop();
        test_reset_mid_sweep();
        test_live_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
